// File: rtl/plot_fifo_scheduler.sv
// plot_fifo_scheduler
//   Drains coordinate packets from the mouse-side plot FIFO (512x36 block RAM,
//   read port owned here), bounds-checks each packet, converts (x,y) to a linear
//   video-memory address and writes the 3-bit colour into the single-ported
//   video RAM during cycles the VGA scan-out reader leaves idle.
//
//   Optional feature: define CLEAR_SCREEN_EN to add a full-screen clear
//   (clear_req / clear_color). Without it those inputs are ignored.
//
// Ports
//   CLK, RST       clock, synchronous active-high reset
//   fifo_addr_in   FIFO write pointer (packet side)
//   fifo_dob       FIFO read data {9'b0, colour[22:20], x[19:10], y[9:0]}
//   fifo_addr_out  FIFO read pointer (block RAM ADDRB)
//   res_hor/ver    active width / height used for the bounds check
//   vga_rd_req     scan-out request, always wins the video RAM
//   vga_rd_addr    scan-out address
//   vga_rd_gnt     scan-out grant (mirrors vga_rd_req)
//   vm_addr/we/wdata  video RAM port
//   busy           high whenever the FSM is not IDLE
//   discard_cnt    saturating count of rejected packets
//   clear_req      one-cycle clear request (CLEAR_SCREEN_EN only)
//   clear_color    background colour for the clear
module plot_fifo_scheduler #(
  parameter int FIFO_AW  = 9,
  parameter int VM_AW    = 19,
  parameter int LINE_W   = 640,
  parameter int N_PIXELS = 307200
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [FIFO_AW-1:0] fifo_addr_in,
  input  logic [31:0]        fifo_dob,
  output logic [FIFO_AW-1:0] fifo_addr_out,
  input  logic [9:0]         res_hor,
  input  logic [9:0]         res_ver,
  input  logic               vga_rd_req,
  input  logic [VM_AW-1:0]   vga_rd_addr,
  output logic               vga_rd_gnt,
  output logic [VM_AW-1:0]   vm_addr,
  output logic               vm_we,
  output logic [2:0]         vm_wdata,
  output logic               busy,
  output logic [7:0]         discard_cnt,
  input  logic               clear_req,
  input  logic [2:0]         clear_color
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3
`ifdef CLEAR_SCREEN_EN
    , CLEAR = 3'd4
`endif
  } state_t;

  state_t             r_state, w_next;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [31:0]        r_pkt;
  logic [VM_AW-1:0]   r_wr_addr;
  logic [2:0]         r_wr_data;
  logic [7:0]         r_discard;

  logic [9:0]         w_x, w_y;
  logic               w_empty, w_pkt_ok, w_we;
  logic [VM_AW-1:0]   w_lin_addr, w_src_addr;
  logic [2:0]         w_src_data;

`ifdef CLEAR_SCREEN_EN
  logic               r_clr_pend;
  logic [VM_AW-1:0]   r_clr_addr;
  logic [2:0]         r_clr_color;
`else
  logic               w_unused;
  assign w_unused = ^{clear_req, clear_color};
`endif

  assign w_x        = r_pkt[19:10];
  assign w_y        = r_pkt[9:0];
  assign w_empty    = (r_rd_ptr == fifo_addr_in);
  assign w_pkt_ok   = (r_pkt[31:23] == 9'd0) && (w_x < res_hor) && (w_y < res_ver);
  // Product is formed in VM_AW bits; in-range packets never exceed it.
  assign w_lin_addr = ({{(VM_AW-10){1'b0}}, w_y} * VM_AW'(LINE_W)) + VM_AW'(w_x);

  always_comb begin
    w_next     = r_state;
    w_we       = 1'b0;
    w_src_addr = r_wr_addr;
    w_src_data = r_wr_data;
    case (r_state)
      IDLE: begin
`ifdef CLEAR_SCREEN_EN
        if (r_clr_pend)    w_next = CLEAR;
        else
`endif
        if (!w_empty)      w_next = READ;
      end
      // ADDRB was sampled on entry; data is valid by the end of this cycle.
      READ:  w_next = CALC;
      CALC:  w_next = w_pkt_ok ? WRITE : IDLE;
      WRITE: begin
        if (!vga_rd_req) begin
          w_we   = 1'b1;
          w_next = IDLE;
        end
      end
`ifdef CLEAR_SCREEN_EN
      CLEAR: begin
        w_src_addr = r_clr_addr;
        w_src_data = r_clr_color;
        if (!vga_rd_req) begin
          w_we = 1'b1;
          if (r_clr_addr == VM_AW'(N_PIXELS - 1)) w_next = IDLE;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // Scan-out always wins; a write only goes out on cycles it leaves idle, and
  // never while reset is asserted so an aborted WRITE leaves memory untouched.
  assign vga_rd_gnt    = vga_rd_req;
  assign vm_addr       = vga_rd_req ? vga_rd_addr : w_src_addr;
  assign vm_we         = w_we & ~RST;
  assign vm_wdata      = w_src_data;
  assign busy          = (r_state != IDLE);
  assign fifo_addr_out = r_rd_ptr;
  assign discard_cnt   = r_discard;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_rd_ptr  <= '0;
      r_pkt     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_discard <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == READ) r_pkt <= fifo_dob;
      if (r_state == CALC) begin
        if (w_pkt_ok) begin
          r_wr_addr <= w_lin_addr;
          r_wr_data <= r_pkt[22:20];
        end else begin
          // Discarded packets still consume their FIFO slot.
          r_rd_ptr <= r_rd_ptr + 1'b1;
          if (r_discard != 8'hFF) r_discard <= r_discard + 8'd1;
        end
      end
      if (r_state == WRITE && w_we) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

`ifdef CLEAR_SCREEN_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_clr_pend  <= 1'b0;
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else if (r_state == CLEAR) begin
      // Requests during an active clear are dropped.
      if (w_we) begin
        r_clr_addr <= r_clr_addr + 1'b1;
        if (r_clr_addr == VM_AW'(N_PIXELS - 1)) r_clr_pend <= 1'b0;
      end
    end else begin
      if (clear_req) begin
        r_clr_pend  <= 1'b1;
        r_clr_color <= clear_color;
      end
      if (r_state == IDLE && r_clr_pend) r_clr_addr <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_plot_fifo_scheduler.sv
module tb_plot_fifo_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [8:0]  fifo_addr_in = '0;
  logic [31:0] fifo_dob = '0;
  logic [8:0]  fifo_addr_out;
  logic [9:0]  res_hor = 10'd640;
  logic [9:0]  res_ver = 10'd480;
  logic        vga_rd_req = 1'b0;
  logic [18:0] vga_rd_addr = '0;
  logic        vga_rd_gnt;
  logic [18:0] vm_addr;
  logic        vm_we;
  logic [2:0]  vm_wdata;
  logic        busy;
  logic [7:0]  discard_cnt;
  logic        clear_req = 1'b0;
  logic [2:0]  clear_color = '0;

  int checks = 0;
  int passes = 0;
  int wr_cnt = 0;
  logic [21:0] wq[$];
  logic [31:0] mem [512];

  plot_fifo_scheduler dut (
    .CLK(CLK), .RST(RST), .fifo_addr_in(fifo_addr_in), .fifo_dob(fifo_dob),
    .fifo_addr_out(fifo_addr_out), .res_hor(res_hor), .res_ver(res_ver),
    .vga_rd_req(vga_rd_req), .vga_rd_addr(vga_rd_addr), .vga_rd_gnt(vga_rd_gnt),
    .vm_addr(vm_addr), .vm_we(vm_we), .vm_wdata(vm_wdata), .busy(busy),
    .discard_cnt(discard_cnt), .clear_req(clear_req), .clear_color(clear_color)
  );

  always #5 CLK = ~CLK;

  // Block RAM read port: one cycle of latency from ADDRB.
  always @(posedge CLK) fifo_dob <= mem[fifo_addr_out];

  // Write monitor: records every issued write and checks arbitration.
  always @(negedge CLK) begin
    if (vm_we) begin
      wr_cnt++;
      wq.push_back({vm_addr, vm_wdata});
      checks++;
      if (vga_rd_req !== 1'b0) $display("FAIL arb_we_during_rd: vm_we=1 with vga_rd_req=%0b, required 0", vga_rd_req);
      else passes++;
    end
  end

  function automatic logic [31:0] mkpkt(input logic [2:0] c, input logic [9:0] x, input logic [9:0] y);
    return {9'b0, c, x, y};
  endfunction

  task automatic test_reset();
    @(posedge CLK); #1;
    RST = 1'b1; vga_rd_req = 1'b1; vga_rd_addr = 19'h12345; fifo_addr_in = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (vga_rd_gnt !== 1'b1) $display("FAIL rst_gnt: got %0b want 1", vga_rd_gnt); else passes++;
    checks++; if (vm_addr !== 19'h12345) $display("FAIL rst_vm_addr: got %0h want 12345", vm_addr); else passes++;
    checks++; if (vm_we !== 1'b0) $display("FAIL rst_we: got %0b want 0", vm_we); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passes++;
    checks++; if (fifo_addr_out !== 9'd0) $display("FAIL rst_ptr: got %0d want 0", fifo_addr_out); else passes++;
    checks++; if (discard_cnt !== 8'd0) $display("FAIL rst_discard: got %0d want 0", discard_cnt); else passes++;
    @(posedge CLK); #1;
    RST = 1'b0; vga_rd_req = 1'b0;
  endtask

  task automatic test_basic_write();
    int w0;
    @(posedge CLK); #1;
    w0 = wr_cnt;
    mem[0] = 32'h0050_A0F0;
    fifo_addr_in = 9'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (vm_we !== 1'b0) $display("FAIL basic_early_we cyc%0d: got %0b want 0", i, vm_we); else passes++;
    end
    @(negedge CLK);
    checks++; if (vm_we !== 1'b1) $display("FAIL basic_we: got %0b want 1", vm_we); else passes++;
    checks++; if (vm_addr !== 19'd153640) $display("FAIL basic_addr: got %0d want 153640", vm_addr); else passes++;
    checks++; if (vm_wdata !== 3'd5) $display("FAIL basic_data: got %0d want 5", vm_wdata); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_write: got %0b want 1", busy); else passes++;
    @(negedge CLK);
    checks++; if (fifo_addr_out !== 9'd1) $display("FAIL basic_ptr: got %0d want 1", fifo_addr_out); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_drop: got %0b want 0", busy); else passes++;
    checks++; if (wr_cnt - w0 !== 1) $display("FAIL basic_wr_count: got %0d want 1", wr_cnt - w0); else passes++;
  endtask

  task automatic test_stall();
    int w0;
    @(posedge CLK); #1;
    w0 = wr_cnt;
    mem[1] = 32'h0050_A0F0;
    fifo_addr_in = 9'd2;
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1;
    vga_rd_req = 1'b1; vga_rd_addr = 19'h7_0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++; if (vm_we !== 1'b0) $display("FAIL stall_we cyc%0d: got %0b want 0", i, vm_we); else passes++;
      checks++; if (vm_addr !== 19'h7_0001) $display("FAIL stall_addr cyc%0d: got %0h want 70001", i, vm_addr); else passes++;
      checks++; if (vga_rd_gnt !== 1'b1) $display("FAIL stall_gnt cyc%0d: got %0b want 1", i, vga_rd_gnt); else passes++;
    end
    @(posedge CLK); #1;
    vga_rd_req = 1'b0;
    @(negedge CLK);
    checks++; if (vm_we !== 1'b1) $display("FAIL stall_release_we: got %0b want 1", vm_we); else passes++;
    checks++; if (vm_addr !== 19'd153640) $display("FAIL stall_release_addr: got %0d want 153640", vm_addr); else passes++;
    @(negedge CLK);
    checks++; if (fifo_addr_out !== 9'd2) $display("FAIL stall_ptr: got %0d want 2", fifo_addr_out); else passes++;
    checks++; if (wr_cnt - w0 !== 1) $display("FAIL stall_wr_count: got %0d want 1", wr_cnt - w0); else passes++;
  endtask

  task automatic test_discard();
    int w0;
    @(posedge CLK); #1;
    w0 = wr_cnt;
    mem[2] = 32'h000A_0000;              // x = 640
    mem[3] = 32'h8000_0000;              // bit 31 set
    mem[4] = mkpkt(3'd1, 10'd0, 10'd480); // y = 480
    fifo_addr_in = 9'd5;
    for (int i = 0; i < 40 && fifo_addr_out !== 9'd5; i++) @(negedge CLK);
    checks++; if (fifo_addr_out !== 9'd5) $display("FAIL discard_ptr: got %0d want 5", fifo_addr_out); else passes++;
    checks++; if (discard_cnt !== 8'd3) $display("FAIL discard_cnt: got %0d want 3", discard_cnt); else passes++;
    checks++; if (wr_cnt - w0 !== 0) $display("FAIL discard_no_write: got %0d want 0", wr_cnt - w0); else passes++;
    @(negedge CLK);
    checks++; if (busy !== 1'b0) $display("FAIL discard_busy: got %0b want 0", busy); else passes++;
  endtask

  task automatic test_reset_mid_write();
    int w0;
    @(posedge CLK); #1;
    w0 = wr_cnt;
    mem[5] = mkpkt(3'd6, 10'd1, 10'd1);
    fifo_addr_in = 9'd6;
    repeat (3) @(negedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1; fifo_addr_in = 9'd0;
    @(negedge CLK);
    checks++; if (vm_we !== 1'b0) $display("FAIL midrst_we: got %0b want 0", vm_we); else passes++;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (fifo_addr_out !== 9'd0) $display("FAIL midrst_ptr: got %0d want 0", fifo_addr_out); else passes++;
    checks++; if (discard_cnt !== 8'd0) $display("FAIL midrst_discard: got %0d want 0", discard_cnt); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %0b want 0", busy); else passes++;
    checks++; if (wr_cnt - w0 !== 0) $display("FAIL midrst_no_write: got %0d want 0", wr_cnt - w0); else passes++;
  endtask

  task automatic test_wrap();
    int w0;
    @(posedge CLK); #1;
    w0 = wr_cnt;
    for (int i = 0; i < 510; i++) mem[i] = mkpkt(3'(i), 10'(i), 10'd1);
    fifo_addr_in = 9'd510;
    for (int i = 0; i < 2600 && fifo_addr_out !== 9'd510; i++) @(negedge CLK);
    checks++; if (fifo_addr_out !== 9'd510) $display("FAIL wrap_fill_ptr: got %0d want 510", fifo_addr_out); else passes++;
    checks++; if (wr_cnt - w0 !== 510) $display("FAIL wrap_fill_count: got %0d want 510", wr_cnt - w0); else passes++;
    @(posedge CLK); #1;
    wq.delete();
    mem[510] = mkpkt(3'd2, 10'd1, 10'd1);
    mem[511] = mkpkt(3'd7, 10'd639, 10'd479);
    mem[0]   = mkpkt(3'd3, 10'd0, 10'd2);
    fifo_addr_in = 9'd1;
    for (int i = 0; i < 60 && fifo_addr_out !== 9'd1; i++) @(negedge CLK);
    checks++; if (fifo_addr_out !== 9'd1) $display("FAIL wrap_ptr: got %0d want 1", fifo_addr_out); else passes++;
    checks++; if (wq.size() !== 3) $display("FAIL wrap_write_count: got %0d want 3", wq.size()); else passes++;
    if (wq.size() >= 3) begin
      checks++; if (wq[0] !== {19'd641, 3'd2}) $display("FAIL wrap_w0: got addr %0d data %0d want 641/2", wq[0][21:3], wq[0][2:0]); else passes++;
      checks++; if (wq[1] !== {19'd307199, 3'd7}) $display("FAIL wrap_w1: got addr %0d data %0d want 307199/7", wq[1][21:3], wq[1][2:0]); else passes++;
      checks++; if (wq[2] !== {19'd1280, 3'd3}) $display("FAIL wrap_w2: got addr %0d data %0d want 1280/3", wq[2][21:3], wq[2][2:0]); else passes++;
    end
    @(negedge CLK);
    checks++; if (busy !== 1'b0) $display("FAIL wrap_busy: got %0b want 0", busy); else passes++;
  endtask

  task automatic test_clear();
    int w0;
    @(posedge CLK); #1;
    w0 = wr_cnt;
    wq.delete();
    clear_req = 1'b1; clear_color = 3'd3;
    @(posedge CLK); #1;
    clear_req = 1'b0; clear_color = 3'd0;
`ifdef CLEAR_SCREEN_EN
    repeat (6) @(negedge CLK);
    checks++; if (busy !== 1'b1) $display("FAIL clear_busy: got %0b want 1", busy); else passes++;
    checks++; if (wq.size() < 3) $display("FAIL clear_started: got %0d writes want >=3", wq.size()); else passes++;
    for (int k = 0; k < 3 && k < wq.size(); k++) begin
      checks++; if (wq[k] !== {19'(k), 3'd3}) $display("FAIL clear_w%0d: got addr %0d data %0d want %0d/3", k, wq[k][21:3], wq[k][2:0], k); else passes++;
    end
    @(posedge CLK); #1; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
`else
    repeat (4) begin
      @(negedge CLK);
      checks++; if (busy !== 1'b0) $display("FAIL clear_ignored_busy: got %0b want 0", busy); else passes++;
    end
    checks++; if (wr_cnt - w0 !== 0) $display("FAIL clear_ignored_write: got %0d want 0", wr_cnt - w0); else passes++;
`endif
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    test_reset();
    test_basic_write();
    test_stall();
    test_discard();
    test_reset_mid_write();
    test_wrap();
    test_clear();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
